// File: rtl/deser_pkg.sv
// Shared definitions for the decoder deserialiser: channel geometry,
// decoder word-mode codes, the merged output word layout and the
// round-robin pick helper used by the arbiter.
package deser_pkg;

    localparam int NCH    = 4;
    localparam int CH_W   = 2;
    localparam int WORD_W = 16;

    // Decoder word-mode field (top three bits of a decoded word).
    typedef enum logic [2:0] {
        MODE_HIT0     = 3'b000,
        MODE_HIT1     = 3'b001,
        MODE_ROC_HDR  = 3'b010,
        MODE_TBM_HDR1 = 3'b100,
        MODE_TBM_HDR0 = 3'b101,
        MODE_TBM_TRL1 = 3'b110,
        MODE_TBM_TRL0 = 3'b111
    } word_mode_e;

    typedef logic [CH_W-1:0] ch_idx_t;

    // Merged output word: source channel above the untouched data word.
    typedef struct packed {
        ch_idx_t           ch;
        logic [WORD_W-1:0] word;
    } out_word_t;

    // First requesting channel found when searching from last+1 upward,
    // modulo NCH. The loop walks offsets downward so the smallest offset
    // is the last (winning) assignment; offset NCH wraps to 'last' itself.
    function automatic ch_idx_t rr_pick(input ch_idx_t last, input logic [NCH-1:0] req);
        ch_idx_t pick;
        ch_idx_t idx;
        pick = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = last + ch_idx_t'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel word buffer. First-word-fall-through: dout always shows the
// oldest stored word. The caller only asserts push when the word can be
// taken (not full, or full and popped in the same cycle) and only asserts
// pop when non-empty. DEPTH must be a power of two so pointers wrap freely.
module chan_fifo
    import deser_pkg::*;
#(
    parameter int   DEPTH = 4,
    parameter int   WIDTH = WORD_W,
    localparam int  PTR_W = $clog2(DEPTH),
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk80,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk80) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write. When full and popped together, wr_ptr equals rd_ptr:
    // the outgoing word is read combinationally before this edge overwrites it.
    // NOTE: the RAM is deliberately not reset; the cleared count makes stale contents unreachable.
    always_ff @(posedge clk80) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/decoder_arbiter.sv
// Merges four decoder channels into one stream. Each channel buffers into
// its own chan_fifo; a round-robin arbiter feeds a single output register
// with a valid/ready handshake. Drops on a full buffer set a sticky flag.
module decoder_arbiter
    import deser_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk80,
    input  logic                     reset,
    input  logic [NCH-1:0]           enable,
    input  logic [NCH-1:0]           wr,
    input  logic [NCH*WORD_W-1:0]    din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W+WORD_W-1:0]   out_data,
    output logic [NCH-1:0]           overflow,
    input  logic                     clr_overflow,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FIFO_DEPTH);

    logic [NCH-1:0]    w_req;
    logic [NCH-1:0]    w_push;
    logic [NCH-1:0]    w_pop;
    logic [NCH-1:0]    w_drop;
    logic [NCH-1:0]    w_full;
    logic [NCH-1:0]    w_empty;
    logic [NCH-1:0]    w_nonempty;
    logic [WORD_W-1:0] w_dout  [NCH];
    logic [CNT_W-1:0]  w_count [NCH];
    logic              w_load;
    ch_idx_t           w_grant;

    out_word_t         r_out_data;
    logic              r_out_valid;
    ch_idx_t           r_last_grant;
    logic [NCH-1:0]    r_overflow;

    // A write counts only on enabled channels; disabled writes vanish silently.
    // A full buffer still accepts when the arbiter pops it this same cycle.
    assign w_req      = wr & enable;
    assign w_push     = w_req & (~w_full | w_pop);
    assign w_drop     = w_req & w_full & ~w_pop;
    assign w_nonempty = ~w_empty;

    // The output register refills whenever it is free or being handed off.
    assign w_load  = (!r_out_valid || out_ready) && (|w_nonempty);
    assign w_grant = rr_pick(r_last_grant, w_nonempty);

    // One-hot pop of the granted channel on a load.
    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        w_pop = '0;
        if (w_load) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        chan_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (WORD_W)
        ) u_fifo (
            .clk80 (clk80),
            .reset (reset),
            .push  (w_push[i]),
            .pop   (w_pop[i]),
            .din   (din[WORD_W*i +: WORD_W]),
            .dout  (w_dout[i]),
            .full  (w_full[i]),
            .empty (w_empty[i]),
            .count (w_count[i])
        );

        // Occupancy must stay in range and agree with the empty flag.
        always_ff @(posedge clk80) begin
            if (!reset) begin
                assert (w_count[i] <= MAX_CNT && ((w_count[i] == '0) == w_empty[i]));
            end
        end
    end

    // Output register and round-robin pointer; valid drops only after a
    // handshake with nothing left to replace the departing word.
    always_ff @(posedge clk80) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_last_grant <= '0;
        end else if (w_load) begin
            r_out_valid     <= 1'b1;
            r_out_data.ch   <= w_grant;
            r_out_data.word <= w_dout[w_grant];
            r_last_grant    <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky drop flags; a drop in the clearing cycle still sets its bit.
    always_ff @(posedge clk80) begin
        if (reset) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (clr_overflow ? '0 : r_overflow) | w_drop;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overflow  = r_overflow;
    assign busy      = (|w_nonempty) || r_out_valid;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Bench for decoder_arbiter: directed scenarios plus a randomized run, all
// shadowed by a queue-based reference model of the merge behaviour.
module tb_decoder_arbiter;

    localparam int D = 4;

    logic        clk80 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  enable = '0;
    logic [3:0]  wr = '0;
    logic [63:0] din = '0;
    logic        out_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        out_valid;
    logic [17:0] out_data;
    logic [3:0]  overflow;
    logic        busy;

    always #5 clk80 = ~clk80;

    decoder_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk80        (clk80),
        .reset        (reset),
        .enable       (enable),
        .wr           (wr),
        .din          (din),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy)
    );

    // Reference model: one queue per channel, the presented word, sticky flags
    // and the channel granted last.
    logic [15:0] mq [4][$];
    logic        m_valid = 1'b0;
    logic [17:0] m_data = '0;
    logic [3:0]  m_ov = '0;
    int          m_lg = 0;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic m_busy();
        for (int c = 0; c < 4; c++) if (mq[c].size() > 0) return 1'b1;
        return m_valid;
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge, and
    // return #1 after the edge so outputs can be sampled.
    task automatic cycle(input logic [3:0] i_en, input logic [3:0] i_wr, input logic [63:0] i_din,
                         input logic i_rdy, input logic i_clr, input logic i_rst);
        int          sz [4];
        int          g;
        bit          any;
        bit          load;
        logic [15:0] w;
        enable = i_en; wr = i_wr; din = i_din;
        out_ready = i_rdy; clr_overflow = i_clr; reset = i_rst;
        if (i_rst) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            m_valid = 1'b0; m_data = '0; m_ov = '0; m_lg = 0;
        end else begin
            any = 1'b0; g = -1;
            for (int c = 0; c < 4; c++) begin
                sz[c] = mq[c].size();
                if (sz[c] > 0) any = 1'b1;
            end
            load = (!m_valid || i_rdy) && any;
            if (load) begin
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && sz[(m_lg + k) % 4] > 0) g = (m_lg + k) % 4;
                w = mq[g].pop_front();
                m_data = {2'(g), w};
                m_valid = 1'b1;
                m_lg = g;
            end else if (i_rdy) begin
                m_valid = 1'b0;
            end
            if (i_clr) m_ov = '0;
            for (int c = 0; c < 4; c++) begin
                if (i_wr[c] && i_en[c]) begin
                    if (sz[c] < D || (load && g == c)) mq[c].push_back(i_din[16*c +: 16]);
                    else m_ov[c] = 1'b1;
                end
            end
        end
        @(posedge clk80);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(4'hF, 4'h0, 64'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(4'h0, 4'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 18'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", out_data); end
        vectors++; if (overflow !== 4'h0) begin miscompares++; $display("FAIL reset_ovf: got %h want 0", overflow); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        // First edge after reset release must already accept a push.
        cycle(4'hF, 4'b0001, 64'h0000_0000_0000_5A5A, 1'b1, 1'b0, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_push_busy: got %b want 1", busy); end
        idle(1'b1);
        vectors++; if (out_data !== 18'h05A5A) begin miscompares++; $display("FAIL first_push_data: got %h want 05a5a", out_data); end
    endtask

    task automatic test_single_word();
        do_reset();
        cycle(4'hF, 4'b0100, 64'h0000_A123_0000_0000, 1'b1, 1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: got %b want 0", out_valid); end
        idle(1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 18'h2A123) begin miscompares++; $display("FAIL single_data: got %h want 2a123", out_data); end
        idle(1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [15:0] wd [4][3];
        logic [63:0] d;
        logic [17:0] got [$];
        logic [17:0] exp;
        int          ch;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) wd[c][n] = 16'($urandom);
            d = {wd[3][n], wd[2][n], wd[1][n], wd[0][n]};
            cycle(4'hF, 4'hF, d, 1'b1, 1'b0, 1'b0);
            if (out_valid) got.push_back(out_data);
        end
        repeat (20) begin
            idle(1'b1);
            if (out_valid) got.push_back(out_data);
        end
        vectors++; if (got.size() != 12) begin miscompares++; $display("FAIL fair_count: got %0d want 12", got.size()); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            ch = (i + 1) % 4;
            exp = {2'(ch), wd[ch][i / 4]};
            vectors++; if (got[i] !== exp) begin miscompares++; $display("FAIL fair_word%0d: got %h want %h", i, got[i], exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [6];
        logic [17:0] got [$];
        do_reset();
        for (int n = 0; n < 5; n++) begin
            w[n] = 16'($urandom);
            cycle(4'hF, 4'b0001, {48'h0, w[n]}, 1'b0, 1'b0, 1'b0);
        end
        vectors++; if (overflow !== 4'h0) begin miscompares++; $display("FAIL bp_no_ovf: got %h want 0", overflow); end
        vectors++; if (out_data !== {2'd0, w[0]} || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_held: got %b/%h want 1/%h", out_valid, out_data, {2'd0, w[0]}); end
        w[5] = 16'($urandom);
        cycle(4'hF, 4'b0001, {48'h0, w[5]}, 1'b0, 1'b0, 1'b0);
        vectors++; if (overflow !== 4'b0001) begin miscompares++; $display("FAIL bp_ovf: got %h want 1", overflow); end
        repeat (10) begin
            if (out_valid) got.push_back(out_data);
            idle(1'b1);
        end
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL bp_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vectors++; if (got[i] !== {2'd0, w[i]}) begin miscompares++; $display("FAIL bp_word%0d: got %h want %h", i, got[i], {2'd0, w[i]}); end
        end
        vectors++; if (overflow !== 4'b0001) begin miscompares++; $display("FAIL bp_sticky: got %h want 1", overflow); end
        cycle(4'hF, 4'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        vectors++; if (overflow !== 4'h0) begin miscompares++; $display("FAIL bp_clear: got %h want 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [15:0] w [6];
        logic [17:0] got [$];
        do_reset();
        for (int n = 0; n < 5; n++) begin
            w[n] = 16'($urandom);
            cycle(4'hF, 4'b1000, {w[n], 48'h0}, 1'b0, 1'b0, 1'b0);
        end
        w[5] = 16'($urandom);
        cycle(4'hF, 4'b1000, {w[5], 48'h0}, 1'b1, 1'b0, 1'b0);
        vectors++; if (overflow[3] !== 1'b0) begin miscompares++; $display("FAIL fullpop_ovf: got %b want 0", overflow[3]); end
        repeat (10) begin
            if (out_valid) got.push_back(out_data);
            idle(1'b1);
        end
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL fullpop_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vectors++; if (got[i] !== {2'd3, w[i+1]}) begin miscompares++; $display("FAIL fullpop_word%0d: got %h want %h", i, got[i], {2'd3, w[i+1]}); end
        end
    endtask

    task automatic test_disable();
        logic [15:0] w [3];
        logic [17:0] got [$];
        int          seen = 0;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            cycle(4'b1110, (n % 2 == 0) ? 4'b0001 : 4'b0000, {48'h0, 16'($urandom)}, 1'b1, 1'b0, 1'b0);
            if (out_valid) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL dis_no_output: got %0d words want 0", seen); end
        vectors++; if (overflow[0] !== 1'b0) begin miscompares++; $display("FAIL dis_ovf: got %b want 0", overflow[0]); end
        for (int n = 0; n < 3; n++) begin
            w[n] = 16'($urandom);
            cycle(4'hF, 4'b0010, {32'h0, w[n], 16'h0}, 1'b0, 1'b0, 1'b0);
        end
        repeat (10) begin
            if (out_valid) got.push_back(out_data);
            cycle(4'b1100, 4'b0010, {32'h0, 16'($urandom), 16'h0}, 1'b1, 1'b0, 1'b0);
        end
        vectors++; if (got.size() != 3) begin miscompares++; $display("FAIL dis_drain_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            vectors++; if (got[i] !== {2'd1, w[i]}) begin miscompares++; $display("FAIL dis_word%0d: got %h want %h", i, got[i], {2'd1, w[i]}); end
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        do_reset();
        for (int n = 0; n < 6; n++)
            cycle(4'hF, (n < 4) ? 4'b0011 : 4'b0010, {32'h0, 16'($urandom), 16'($urandom)}, 1'b0, 1'b0, 1'b0);
        vectors++; if (overflow !== 4'b0010 || out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got ovf %h valid %b want 2/1", overflow, out_valid); end
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++; if (overflow !== 4'h0) begin miscompares++; $display("FAIL mid_ovf: got %h want 0", overflow); end
        repeat (8) begin
            idle(1'b1);
            if (out_valid) stale++;
        end
        vectors++; if (stale != 0) begin miscompares++; $display("FAIL mid_stale: got %0d words want 0", stale); end
    endtask

    task automatic test_random();
        logic       rdy;
        logic       clr;
        logic       rst;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 7) < (((i / 100) % 2 == 1) ? 2 : 7));
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 249) == 0);
            cycle(4'($urandom), 4'($urandom), {$urandom(), $urandom()}, rdy, clr, rst);
            vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, m_valid); end
            vectors++; if (out_data !== m_data) begin miscompares++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, m_data); end
            vectors++; if (overflow !== m_ov) begin miscompares++; $display("FAIL rnd_ovf@%0d: got %h want %h", i, overflow, m_ov); end
            vectors++; if (busy !== m_busy()) begin miscompares++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, m_busy()); end
        end
    endtask

    initial begin
        @(posedge clk80);
        #1;
        test_reset();
        test_single_word();
        test_fairness();
        test_backpressure();
        test_full_pop();
        test_disable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
